// File: rtl/alu_mdu.sv
// alu_mdu: combinational ALU plus a multi-cycle multiply/divide unit (MDU)
// with HI/LO result registers.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   A, B            operands, shared by the ALU and the MDU
//   ALUOp  [3:0]    ALU select: 0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra,
//                   6 xor, 7 nor, 8 sll, 9 slt, 10 sltu, 11-15 give zero
//   C, Zero         combinational ALU result and its zero flag
//   start, MDOp     one-cycle MDU request: 0 mult, 1 multu, 2 div, 3 divu,
//                   4 mthi, 5 mtlo, 6-7 no-op
//   busy            high while a multiply/divide is in flight
//   HI, LO          result registers
//
// The MDU latches its operands on acceptance and then counts cycles. The
// result is a combinational function of the latched operands, so it is
// settled long before the completion edge that writes HI/LO. This makes the
// latency exactly MULT_CYCLES / DIV_CYCLES regardless of WIDTH.
module alu_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  output logic             Zero,
  input  logic             start,
  input  logic [2:0]       MDOp,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // ---------------------------------------------------------------------
  // ALU (purely combinational, independent of MDU state and reset)
  // ---------------------------------------------------------------------
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_c;

  assign shamt = B[SHW-1:0];

  always_comb begin
    alu_c = '0;
    case (ALUOp)
      4'd0:    alu_c = A + B;
      4'd1:    alu_c = A - B;
      4'd2:    alu_c = A & B;
      4'd3:    alu_c = A | B;
      4'd4:    alu_c = A >> shamt;
      4'd5:    alu_c = $unsigned($signed(A) >>> shamt);
      4'd6:    alu_c = A ^ B;
      4'd7:    alu_c = ~(A | B);
      4'd8:    alu_c = A << shamt;
      4'd9:    alu_c = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd10:   alu_c = {{(WIDTH-1){1'b0}}, (A < B)};
      default: alu_c = '0;
    endcase
  end

  assign C    = alu_c;
  assign Zero = (alu_c == '0);

  // ---------------------------------------------------------------------
  // MDU state
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // ---------------------------------------------------------------------
  // Result datapath on the latched operands
  // ---------------------------------------------------------------------
  logic             is_signed;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;

  // mult and div are the signed variants (op bit 0 clear)
  assign is_signed = ~op_q[0];

  // One 2W x 2W multiplier serves both: sign- or zero-extend the operands,
  // and the low 2W bits of the product are correct either way.
  assign mul_a = {{WIDTH{is_signed & a_q[WIDTH-1]}}, a_q};
  assign mul_b = {{WIDTH{is_signed & b_q[WIDTH-1]}}, b_q};
  assign prod  = mul_a * mul_b;

  // Signed division via magnitudes, then sign fix-up. The most-negative
  // dividend has magnitude 2^(W-1), which is representable unsigned, so
  // MIN / -1 naturally yields quotient MIN and remainder 0.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe;
  logic [WIDTH-1:0] q_mag, r_mag;
  logic [WIDTH-1:0] quot, rem;

  assign a_neg  = is_signed & a_q[WIDTH-1];
  assign b_neg  = is_signed & b_q[WIDTH-1];
  assign a_mag  = a_neg ? (~a_q + 1'b1) : a_q;
  assign b_mag  = b_neg ? (~b_q + 1'b1) : b_q;
  assign b_zero = (b_q == '0);
  // keep the divider away from x/0; the zero case is overridden below
  assign b_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;

  always_comb begin
    quot = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem  = a_neg ? (~r_mag + 1'b1) : r_mag;
    if (b_zero) begin
      quot = '1;
      rem  = a_q;
    end
  end

  // ---------------------------------------------------------------------
  // Control: next-state / next-data
  // ---------------------------------------------------------------------
  logic done, accept;

  // done marks the completion edge; a new start is legal on that edge too,
  // so back-to-back operations lose no cycle.
  assign done   = (state_q == S_RUN) && (cnt_q == CNT_ONE);
  assign accept = start && ((state_q == S_IDLE) || done);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (state_q == S_RUN) begin
      if (done) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (op_q[1]) begin
          hi_d = rem;
          lo_d = quot;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    // Acceptance is evaluated after completion so that a move issued on the
    // completion edge lands on top of the finished result.
    if (accept) begin
      case (MDOp)
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
          state_d = S_RUN;
          op_d    = MDOp;
          a_d     = A;
          b_d     = B;
          cnt_d   = MDOp[1] ? DIV_N : MULT_N;
        end
        MD_MTHI: hi_d = A;
        MD_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: a default 32-bit instance plus a 16-bit instance with
// single-cycle multiply for back-to-back issue. Expected HI/LO pairs are
// queued when an operation is driven and popped at its completion cycle.
module tb_alu_mdu;

  logic        clk;
  logic        rst_n;

  // 32-bit instance
  logic [31:0] a, b, c, hi, lo;
  logic [3:0]  alu_op;
  logic        zero, start, busy;
  logic [2:0]  md_op;

  // 16-bit instance
  logic [15:0] a16, b16, c16, hi16, lo16;
  logic [3:0]  alu_op16;
  logic        zero16, start16, busy16;
  logic [2:0]  md_op16;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] sb16_q[$];
  logic [31:0] model_hi, model_lo;

  int checks = 0;
  int errors = 0;

  alu_mdu u_dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .ALUOp(alu_op), .C(c), .Zero(zero),
    .start(start), .MDOp(md_op), .busy(busy), .HI(hi), .LO(lo)
  );

  alu_mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .ALUOp(alu_op16), .C(c16),
    .Zero(zero16), .start(start16), .MDOp(md_op16), .busy(busy16),
    .HI(hi16), .LO(lo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] oa,
                         input logic [31:0] ob, input logic [31:0] ec, input logic ez);
    alu_op = op; a = oa; b = ob;
    #1;
    chk({tag, " C"}, c, ec);
    chk({tag, " Zero"}, zero, ez);
  endtask

  // Independent reference for random MDU cases (HI in upper half).
  function automatic logic [63:0] ref32(input logic [2:0] op, input logic [31:0] oa,
                                        input logic [31:0] ob);
    longint sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(oa));
    sb = longint'($signed(ob));
    ua = {32'd0, oa};
    ub = {32'd0, ob};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (ob == 0) return {oa, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (ob == 0) return {oa, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Drive one MDU request on the 32-bit instance and follow it to completion.
  // poke re-asserts start two edges after acceptance; it must be ignored.
  task automatic md32(input string tag, input logic [2:0] op, input logic [31:0] oa,
                      input logic [31:0] ob, input logic [31:0] ehi,
                      input logic [31:0] elo, input bit poke);
    exp_t e;
    int   n;
    sb_q.push_back('{hi: ehi, lo: elo});
    @(negedge clk);
    a = oa; b = ob; md_op = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    if (op >= 3'd4) begin
      chk({tag, " busy"}, busy, 1'b0);
      e = sb_q.pop_front();
      chk({tag, " HI"}, hi, e.hi);
      chk({tag, " LO"}, lo, e.lo);
    end else begin
      n = (op < 3'd2) ? 5 : 10;
      for (int i = 0; i < n; i++) begin
        chk({tag, " busy run"}, busy, 1'b1);
        if (i == 0) begin
          chk({tag, " HI hold"}, hi, model_hi);
          chk({tag, " LO hold"}, lo, model_lo);
        end
        if (poke && i == 1) begin
          start = 1'b1; md_op = 3'd1; a = 32'd3; b = 32'd3;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
      start = 1'b0;
      chk({tag, " busy done"}, busy, 1'b0);
      e = sb_q.pop_front();
      chk({tag, " HI"}, hi, e.hi);
      chk({tag, " LO"}, lo, e.lo);
      @(negedge clk);
      chk({tag, " busy after"}, busy, 1'b0);
    end
    model_hi = ehi;
    model_lo = elo;
  endtask

  initial begin
    logic [63:0] r;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic [31:0] e16;

    rst_n = 1'b0;
    a = '0; b = '0; alu_op = '0; start = 1'b0; md_op = '0;
    a16 = '0; b16 = '0; alu_op16 = '0; start16 = 1'b0; md_op16 = '0;
    model_hi = '0; model_lo = '0;

    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset HI", hi, 32'd0);
    chk("reset LO", lo, 32'd0);
    alu_chk("alu add in reset", 4'd0, 32'd7, 32'd9, 32'd16, 1'b0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU table
    alu_chk("add wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    alu_chk("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    alu_chk("and", 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
    alu_chk("or", 4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0);
    alu_chk("srl", 4'd4, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0);
    alu_chk("sra", 4'd5, 32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFFF, 1'b0);
    alu_chk("xor", 4'd6, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);
    alu_chk("nor", 4'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    alu_chk("sll", 4'd8, 32'd1, 32'h3F, 32'h8000_0000, 1'b0);
    alu_chk("slt", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    alu_chk("sltu", 4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    alu_chk("op12", 4'd12, 32'h1234_5678, 32'd1, 32'd0, 1'b1);
    alu_chk("sra pos", 4'd5, 32'h7000_0000, 32'd4, 32'h0700_0000, 1'b0);

    // MDU table
    md32("mult -3*7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    md32("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    md32("divu 100/7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    md32("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    md32("div 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    md32("div min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    md32("div 5/0", 3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
    md32("divu max/0", 3'd3, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    md32("mthi", 3'd4, 32'h0000_ABCD, 32'd0, 32'h0000_ABCD, model_lo, 1'b0);
    md32("noop", 3'd6, 32'h5555_5555, 32'd9, model_hi, model_lo, 1'b0);

    for (int k = 0; k < 4; k++) begin
      ra = $urandom; rb = $urandom;
      if (k == 3) rb = rb & 32'h0000_00FF;
      rop = 3'(k);
      r = ref32(rop, ra, rb);
      md32("random", rop, ra, rb, r[63:32], r[31:0], 1'b0);
    end

    // mtlo, then reset in the middle of a multiply
    md32("mtlo", 3'd5, 32'h0000_1234, 32'd0, model_hi, 32'h0000_1234, 1'b0);
    @(negedge clk);
    a = 32'd11; b = 32'd13; md_op = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-reset busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort HI", hi, 32'd0);
    chk("abort LO", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post-abort busy", busy, 1'b0);
    chk("post-abort HI", hi, 32'd0);
    chk("post-abort LO", lo, 32'd0);

    // Back-to-back on the 16-bit, single-cycle multiply instance
    @(negedge clk);
    a16 = 16'hFFFD; b16 = 16'd7; md_op16 = 3'd0; start16 = 1'b1;
    sb16_q.push_back(32'hFFFF_FFEB);
    @(negedge clk);
    chk("b2b busy1", busy16, 1'b1);
    a16 = 16'h0123; b16 = 16'h0100; md_op16 = 3'd1;
    sb16_q.push_back(32'h0001_2300);
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'hAAAA; b16 = 16'h5555;
    chk("b2b busy2", busy16, 1'b1);
    e16 = sb16_q.pop_front();
    chk("b2b first", {hi16, lo16}, e16);
    @(negedge clk);
    chk("b2b busy end", busy16, 1'b0);
    e16 = sb16_q.pop_front();
    chk("b2b second", {hi16, lo16}, e16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
